// File: rtl/cflog_pkg.sv
// Shared definitions for the control-flow log ring memory: pointer sizing,
// control-word placement and the write-arbiter state encoding.
package cflog_pkg;

  // Bit of the control word that clears the log when written as 1.
  localparam int CLR_BIT = 0;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // Word-index width for a log of depth_pairs src/dest pairs.
  function automatic int ptr_w(input int depth_pairs);
    return $clog2(2 * depth_pairs);
  endfunction

  // Control word sits directly after the last log word.
  function automatic int ctrl_offset(input int depth_pairs);
    return 2 * depth_pairs;
  endfunction

endpackage

// File: rtl/cflog_ring_mem_if.sv
// Peripheral bus and the two hardware write channels of the log memory.
// Handshake: a pair transfers on a rising edge where valid and ready are both 1;
// ready never depends on valid in the same cycle, and an unaccepted request is
// not remembered, so the requester keeps valid high until it sees ready.
interface cflog_ring_mem_if #(
  parameter int DATA_W = 16
);
  logic [13:0]       per_addr;
  logic [15:0]       per_din;
  logic              per_en;
  logic [1:0]        per_we;
  logic [15:0]       per_dout;
  logic              cfa_wr_valid;
  logic              cfa_wr_ready;
  logic [DATA_W-1:0] cfa_src;
  logic [DATA_W-1:0] cfa_dest;
  logic              spec_wr_valid;
  logic              spec_wr_ready;
  logic [DATA_W-1:0] spec_upper;
  logic [DATA_W-1:0] spec_lower;

  modport master (
    output per_addr, per_din, per_en, per_we,
    output cfa_wr_valid, cfa_src, cfa_dest,
    output spec_wr_valid, spec_upper, spec_lower,
    input  per_dout, cfa_wr_ready, spec_wr_ready
  );

  modport slave (
    input  per_addr, per_din, per_en, per_we,
    input  cfa_wr_valid, cfa_src, cfa_dest,
    input  spec_wr_valid, spec_upper, spec_lower,
    output per_dout, cfa_wr_ready, spec_wr_ready
  );
endinterface

// File: rtl/cflog_wr_arb.sv
// Merges the spec and CFA write channels into one pair-write strobe; a CFA
// request colliding with a spec request is parked for exactly one cycle.
module cflog_wr_arb
  import cflog_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              mclk,
  input  logic              puc_rst_n,
  input  logic              clr,
  input  logic              cfa_wr_valid,
  input  logic [DATA_W-1:0] cfa_src,
  input  logic [DATA_W-1:0] cfa_dest,
  input  logic              spec_wr_valid,
  input  logic [DATA_W-1:0] spec_upper,
  input  logic [DATA_W-1:0] spec_lower,
  output logic              cfa_wr_ready,
  output logic              spec_wr_ready,
  output logic              wr_stb,
  output logic [DATA_W-1:0] wr_a,
  output logic [DATA_W-1:0] wr_b,
  output arb_state_e        arb_state
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] buf_src_q, buf_dest_q;

  always_ff @(posedge mclk) begin
    if (!puc_rst_n) state_q <= ARB_IDLE;
    else            state_q <= state_d;
  end

  // Holding buffer is data only; occupancy lives in state_q.
  always_ff @(posedge mclk) begin
    if (state_q == ARB_IDLE && spec_wr_valid && cfa_wr_valid) begin
      buf_src_q  <= cfa_src;
      buf_dest_q <= cfa_dest;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_stb        = 1'b0;
    wr_a          = spec_upper;
    wr_b          = spec_lower;
    cfa_wr_ready  = (state_q == ARB_IDLE);
    spec_wr_ready = (state_q == ARB_IDLE);
    case (state_q)
      ARB_IDLE: begin
        if (spec_wr_valid) begin
          wr_stb = 1'b1;
          if (cfa_wr_valid) state_d = ARB_HOLD;
        end else if (cfa_wr_valid) begin
          wr_stb = 1'b1;
          wr_a   = cfa_src;
          wr_b   = cfa_dest;
        end
      end
      ARB_HOLD: begin
        wr_stb  = 1'b1;
        wr_a    = buf_src_q;
        wr_b    = buf_dest_q;
        state_d = ARB_IDLE;
      end
    endcase
    if (clr) state_d = ARB_IDLE;
  end

  assign arb_state = state_q;

endmodule

// File: rtl/cflog_ring_mem.sv
// Control-flow log: pairs from the CFA and spec channels land in a small RAM
// that software reads (and clears) through the peripheral bus.
module cflog_ring_mem
  import cflog_pkg::*;
#(
  parameter int          DEPTH_PAIRS   = 64,
  parameter int          DATA_W        = 16,
  parameter logic [13:0] BASE_PER_ADDR = 14'h00d8,
  parameter bit          WRAP_EN       = 1'b0,
  localparam int         PTR_W         = ptr_w(DEPTH_PAIRS)
) (
  input  logic              mclk,
  input  logic              puc_rst_n,
  cflog_ring_mem_if.slave   bus,
  output logic [PTR_W-1:0]  log_ptr,
  output logic              log_full,
  output logic              log_ovf,
  output logic [DATA_W-1:0] bd_src,
  output logic [DATA_W-1:0] bd_dest,
  output logic [DATA_W-1:0] prev_src,
  output logic [DATA_W-1:0] prev_dest
);

  localparam int               NW        = 2 * DEPTH_PAIRS;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NW - 2);
  localparam logic [13:0]      CTRL_ADDR = 14'(int'(BASE_PER_ADDR) + ctrl_offset(DEPTH_PAIRS));

  logic [DATA_W-1:0] mem [NW];
  logic [PTR_W-1:0]  ptr_q, bd_idx, prev_idx;
  logic              full_q, ovf_q, clr, wr_stb, wr_take, bd_ok, prev_ok;
  logic [DATA_W-1:0] wr_a, wr_b;
  logic [15:0]       ctrl_word, rd_word;
  int                rd_off;
  arb_state_e        arb_state_dbg;
  logic              unused_ok;

  assign clr = bus.per_en && (bus.per_we != 2'b00) && (bus.per_addr == CTRL_ADDR)
               && bus.per_din[CLR_BIT];

  cflog_wr_arb #(.DATA_W(DATA_W)) u_arb (
    .mclk          (mclk),
    .puc_rst_n     (puc_rst_n),
    .clr           (clr),
    .cfa_wr_valid  (bus.cfa_wr_valid),
    .cfa_src       (bus.cfa_src),
    .cfa_dest      (bus.cfa_dest),
    .spec_wr_valid (bus.spec_wr_valid),
    .spec_upper    (bus.spec_upper),
    .spec_lower    (bus.spec_lower),
    .cfa_wr_ready  (bus.cfa_wr_ready),
    .spec_wr_ready (bus.spec_wr_ready),
    .wr_stb        (wr_stb),
    .wr_a          (wr_a),
    .wr_b          (wr_b),
    .arb_state     (arb_state_dbg)
  );

  // Reset and clear both kill the strobe, so a parked pair never lands.
  assign wr_take = puc_rst_n && !clr && wr_stb && (WRAP_EN || !full_q);

  always_ff @(posedge mclk) begin
    if (wr_take) begin
      mem[ptr_q]               <= wr_a;
      mem[ptr_q + PTR_W'(1)]   <= wr_b;
    end
  end

  always_ff @(posedge mclk) begin
    if (!puc_rst_n || clr) begin
      ptr_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (wr_stb) begin
      if (!WRAP_EN && full_q) begin
        ovf_q <= 1'b1;
      end else if (ptr_q == LAST_PTR) begin
        ptr_q  <= '0;
        full_q <= 1'b1;
        if (WRAP_EN) ovf_q <= 1'b1;
      end else begin
        ptr_q <= ptr_q + PTR_W'(2);
      end
    end
  end

  // Taps look back one and two pairs from the write pointer, modulo the ring.
  assign bd_idx   = PTR_W'((int'(ptr_q) + NW - 2) % NW);
  assign prev_idx = PTR_W'((int'(ptr_q) + 2 * NW - 4) % NW);
  assign bd_ok    = puc_rst_n && (full_q || ptr_q != '0);
  assign prev_ok  = puc_rst_n && ((full_q && DEPTH_PAIRS >= 2) || int'(ptr_q) >= 4);

  assign bd_src    = bd_ok   ? mem[bd_idx]                : '0;
  assign bd_dest   = bd_ok   ? mem[bd_idx + PTR_W'(1)]   : '0;
  assign prev_src  = prev_ok ? mem[prev_idx]              : '0;
  assign prev_dest = prev_ok ? mem[prev_idx + PTR_W'(1)] : '0;

  always_comb begin
    rd_off                = int'(bus.per_addr) - int'(BASE_PER_ADDR);
    ctrl_word             = '0;
    ctrl_word[15]         = ovf_q;
    ctrl_word[14]         = full_q;
    ctrl_word[PTR_W-1:0]  = ptr_q;
    rd_word               = '0;
    if (puc_rst_n && bus.per_en && bus.per_we == 2'b00) begin
      if (rd_off >= 0 && rd_off < NW) rd_word = 16'(mem[PTR_W'(rd_off)]);
      else if (rd_off == NW)          rd_word = ctrl_word;
    end
  end

  assign bus.per_dout = rd_word;
  assign log_ptr      = ptr_q;
  assign log_full     = full_q;
  assign log_ovf      = ovf_q;
  assign unused_ok    = ^{bus.per_din, arb_state_dbg};

endmodule
